// File: rtl/pipe_pkg.sv
// Shared constants for the ID/EX pipeline register: default field widths and
// bit positions inside the packed EX control field.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int WB_W_DEF    = 2;
  localparam int M_W_DEF     = 3;
  localparam int ALUOP_W_DEF = 3;

  // EX field layout: [0]=RegDst, [ALUOP_W:1]=ALUOp, [ALUOP_W+1]=ALUSrc
  localparam int EX_REGDST_BIT  = 0;
  localparam int EX_ALUOP_LSB   = 1;
  localparam int EX_ALUSRC_OFS  = 1;

endpackage

// File: rtl/id_ex_payload_reg.sv
// One ID/EX bundle register: loads on enable, zeroes control bits on flush
// while leaving the data bits untouched.
module id_ex_payload_reg #(
  parameter int CTRL_W = 10,
  parameter int DAT_W  = 138
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DAT_W-1:0]  i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DAT_W-1:0]  o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DAT_W-1:0]  r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register built as a two-entry skid buffer (main + skid).
// Outputs come only from the main entry, so every output is registered.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int WB_W    = WB_W_DEF,
  parameter int M_W     = M_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clkIDEX,
  input  logic               rstIDEX,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WB_W-1:0]    inWB,
  input  logic [M_W-1:0]     inM,
  input  logic [ALUOP_W+1:0] inEX,
  input  logic [DATA_W-1:0]  inPC4,
  input  logic [DATA_W-1:0]  inBR1,
  input  logic [DATA_W-1:0]  inBR2,
  input  logic [DATA_W-1:0]  inSE,
  input  logic [REG_W-1:0]   inRt,
  input  logic [REG_W-1:0]   inRd,
  input  logic               flush,
  output logic               outValid,
  input  logic               outReady,
  output logic [WB_W-1:0]    outWB,
  output logic [M_W-1:0]     outM,
  output logic               outRegDst,
  output logic [ALUOP_W-1:0] outALUOp,
  output logic               outALUSrc,
  output logic [DATA_W-1:0]  outPC4,
  output logic [DATA_W-1:0]  outBR1,
  output logic [DATA_W-1:0]  outBR2,
  output logic [DATA_W-1:0]  outSE,
  output logic [REG_W-1:0]   outRt,
  output logic [REG_W-1:0]   outRd,
  output logic [1:0]         dbgState
);

  // Handshake: a bundle moves in on a cycle with inValid && inReady and moves
  // out on a cycle with outValid && outReady; flush overrides both directions.

  localparam int EX_W   = ALUOP_W + 2;
  localparam int CTRL_W = WB_W + M_W + EX_W;
  localparam int DAT_W  = 4 * DATA_W + 2 * REG_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_in_ready;
  logic   r_out_valid;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main;
  logic w_load_skid;
  logic w_main_from_skid;

  logic [CTRL_W-1:0] w_in_ctrl;
  logic [DAT_W-1:0]  w_in_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DAT_W-1:0]  w_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DAT_W-1:0]  w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DAT_W-1:0]  w_main_data;
  logic [EX_W-1:0]   w_ex;

  assign w_in_xfer  = inValid && r_in_ready;
  assign w_out_xfer = r_out_valid && outReady;

  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_next      = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        case ({w_in_xfer, w_out_xfer})
          2'b10: begin
            w_next      = S_TWO;
            w_load_skid = 1'b1;
          end
          2'b01: w_next = S_EMPTY;
          2'b11: w_load_main = 1'b1;
          default: w_next = S_ONE;
        endcase
      end
      S_TWO: begin
        if (w_out_xfer) begin
          w_next           = S_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
    // A squash discards the incoming bundle too, so no entry may load.
    if (flush) begin
      w_next           = S_EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clkIDEX or posedge rstIDEX) begin
    if (rstIDEX) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != S_TWO);
      r_out_valid <= (w_next != S_EMPTY);
    end
  end

  assign w_in_ctrl     = {inWB, inM, inEX};
  assign w_in_data     = {inPC4, inBR1, inBR2, inSE, inRt, inRd};
  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : w_in_ctrl;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : w_in_data;

  id_ex_payload_reg #(.CTRL_W(CTRL_W), .DAT_W(DAT_W)) u_main (
    .clk     (clkIDEX),
    .rst     (rstIDEX),
    .i_load  (w_load_main),
    .i_clear (flush),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  id_ex_payload_reg #(.CTRL_W(CTRL_W), .DAT_W(DAT_W)) u_skid (
    .clk     (clkIDEX),
    .rst     (rstIDEX),
    .i_load  (w_load_skid),
    .i_clear (flush),
    .i_ctrl  (w_in_ctrl),
    .i_data  (w_in_data),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  assign {outWB, outM, w_ex} = w_main_ctrl;
  assign {outPC4, outBR1, outBR2, outSE, outRt, outRd} = w_main_data;

  assign outRegDst = w_ex[EX_REGDST_BIT];
  assign outALUOp  = w_ex[EX_ALUOP_LSB +: ALUOP_W];
  assign outALUSrc = w_ex[ALUOP_W + EX_ALUSRC_OFS];

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign dbgState = r_state;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vectors, scoreboard of accepted bundles
// checked in order by a monitor, plus directed state/handshake checks.
module tb_id_ex_pipe;

  localparam int BW = 2 + 3 + 5 + 4 * 32 + 2 * 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [1:0]  inWB = '0;
  logic [2:0]  inM = '0;
  logic [4:0]  inEX = '0;
  logic [31:0] inPC4 = '0, inBR1 = '0, inBR2 = '0, inSE = '0;
  logic [4:0]  inRt = '0, inRd = '0;
  logic        flush = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [1:0]  outWB;
  logic [2:0]  outM;
  logic        outRegDst;
  logic [2:0]  outALUOp;
  logic        outALUSrc;
  logic [31:0] outPC4, outBR1, outBR2, outSE;
  logic [4:0]  outRt, outRd;
  logic [1:0]  dbgState;

  // 64-bit data / 6-bit register build
  logic        v64 = 1'b0;
  logic        rdy64;
  logic [63:0] se64 = '0;
  logic        ov64;
  logic [1:0]  wb64;
  logic [2:0]  m64;
  logic        rd64, as64;
  logic [2:0]  op64;
  logic [63:0] pc64o, b1o, b2o, se64o;
  logic [5:0]  rt64o, rd64o;
  logic [1:0]  st64;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  id_ex_pipe u_dut (
    .clkIDEX(clk), .rstIDEX(rst), .inValid(inValid), .inReady(inReady),
    .inWB(inWB), .inM(inM), .inEX(inEX), .inPC4(inPC4), .inBR1(inBR1),
    .inBR2(inBR2), .inSE(inSE), .inRt(inRt), .inRd(inRd), .flush(flush),
    .outValid(outValid), .outReady(outReady), .outWB(outWB), .outM(outM),
    .outRegDst(outRegDst), .outALUOp(outALUOp), .outALUSrc(outALUSrc),
    .outPC4(outPC4), .outBR1(outBR1), .outBR2(outBR2), .outSE(outSE),
    .outRt(outRt), .outRd(outRd), .dbgState(dbgState)
  );

  id_ex_pipe #(.DATA_W(64), .REG_W(6)) u_dut64 (
    .clkIDEX(clk), .rstIDEX(rst), .inValid(v64), .inReady(rdy64),
    .inWB(2'b00), .inM(3'b000), .inEX(5'b00000), .inPC4(64'd0), .inBR1(64'd0),
    .inBR2(64'd0), .inSE(se64), .inRt(6'd0), .inRd(6'd0), .flush(1'b0),
    .outValid(ov64), .outReady(1'b1), .outWB(wb64), .outM(m64),
    .outRegDst(rd64), .outALUOp(op64), .outALUSrc(as64),
    .outPC4(pc64o), .outBR1(b1o), .outBR2(b2o), .outSE(se64o),
    .outRt(rt64o), .outRd(rd64o), .dbgState(st64)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver
  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] wb,
                       input logic [2:0] m, input logic [4:0] ex);
    inValid = v;
    inPC4   = pc;
    inBR1   = pc + 32'd1;
    inBR2   = pc + 32'd2;
    inSE    = pc ^ 32'hFFFF_0000;
    inRt    = pc[4:0];
    inRd    = ~pc[4:0];
    inWB    = wb;
    inM     = m;
    inEX    = ex;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard fill: record each accepted bundle; squash and reset empty it
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else if (flush) exp_q.delete();
    else if (inValid && inReady)
      exp_q.push_back({inWB, inM, inEX, inPC4, inBR1, inBR2, inSE, inRt, inRd});
  end

  // Monitor: compare every delivered bundle against the head of the queue
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc4 %0h expected no bundle", outPC4);
      end else begin
        logic [BW-1:0] e;
        logic [BW-1:0] a;
        e = exp_q.pop_front();
        a = {outWB, outM, outALUSrc, outALUOp, outRegDst, outPC4, outBR1, outBR2,
             outSE, outRt, outRd};
        if (a !== e) begin
          errors++;
          $display("FAIL sb_bundle got %0h expected %0h", a, e);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", outValid, 0);
    chk("rst_in_ready", inReady, 1);
    chk("rst_out_wb", outWB, 0);
    chk("rst_state", dbgState, 0);
    step();
    rst = 1'b0;

    // Streaming with decode on the third bundle
    outReady = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 32'(4 * k), 2'b10, 3'b010, (k == 3) ? 5'b10111 : 5'b00001);
      step();
      chk("stream_pc4", outPC4, 64'(4 * k));
      chk("stream_valid", outValid, 1);
      chk("stream_in_ready", inReady, 1);
    end
    chk("dec_regdst", outRegDst, 1);
    chk("dec_aluop", outALUOp, 3'b011);
    chk("dec_alusrc", outALUSrc, 1);
    drive(1'b0, 32'd0, 2'b00, 3'b000, 5'b00000);
    step();
    chk("drain_valid", outValid, 0);
    chk("drain_state", dbgState, 0);

    // Backpressure
    outReady = 1'b0;
    drive(1'b1, 32'd4, 2'b01, 3'b001, 5'b00110);
    step();
    chk("bp_state_one", dbgState, 1);
    drive(1'b1, 32'd8, 2'b10, 3'b100, 5'b01001);
    step();
    chk("bp_state_two", dbgState, 2);
    chk("bp_in_ready", inReady, 0);
    chk("bp_hold_pc4", outPC4, 4);
    drive(1'b1, 32'd12, 2'b11, 3'b011, 5'b11000);
    step();
    chk("bp_still_two", dbgState, 2);
    chk("bp_still_pc4", outPC4, 4);
    drive(1'b0, 32'd0, 2'b00, 3'b000, 5'b00000);
    outReady = 1'b1;
    step();
    chk("bp_second_pc4", outPC4, 8);
    chk("bp_back_one", dbgState, 1);
    step();
    chk("bp_empty_valid", outValid, 0);

    // Flush with two held and a bundle arriving
    outReady = 1'b0;
    drive(1'b1, 32'd20, 2'b11, 3'b111, 5'b11111);
    step();
    drive(1'b1, 32'd24, 2'b11, 3'b111, 5'b11111);
    step();
    chk("fl_state_two", dbgState, 2);
    drive(1'b1, 32'd28, 2'b11, 3'b111, 5'b11111);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 2'b00, 3'b000, 5'b00000);
    chk("fl_valid", outValid, 0);
    chk("fl_wb", outWB, 0);
    chk("fl_m", outM, 0);
    chk("fl_alusrc", outALUSrc, 0);
    chk("fl_in_ready", inReady, 1);
    outReady = 1'b1;
    step();
    chk("fl_absent", outValid, 0);

    // Flush while empty
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fle_valid", outValid, 0);
    chk("fle_in_ready", inReady, 1);

    // Asynchronous reset with two held
    outReady = 1'b0;
    drive(1'b1, 32'd40, 2'b01, 3'b010, 5'b00011);
    step();
    drive(1'b1, 32'd44, 2'b10, 3'b001, 5'b00101);
    step();
    chk("ar_state_two", dbgState, 2);
    drive(1'b0, 32'd0, 2'b00, 3'b000, 5'b00000);
    rst = 1'b1;
    #1;
    chk("ar_valid", outValid, 0);
    chk("ar_in_ready", inReady, 1);
    chk("ar_wb", outWB, 0);
    chk("ar_pc4", outPC4, 0);
    #1 rst = 1'b0;
    outReady = 1'b1;
    drive(1'b1, 32'd48, 2'b01, 3'b101, 5'b01010);
    step();
    chk("ar_first_pc4", outPC4, 48);
    chk("ar_first_valid", outValid, 1);
    drive(1'b0, 32'd0, 2'b00, 3'b000, 5'b00000);
    step();

    // Wide build passes the immediate unchanged
    v64  = 1'b1;
    se64 = 64'hFFFF_0000_0000_0001;
    step();
    v64 = 1'b0;
    chk("w64_se", se64o, 64'hFFFF_0000_0000_0001);
    chk("w64_valid", ov64, 1);
    step();

    chk("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of PC+4, register-read and sign-extend data fields.
REQ-002 Parameter REG_W, default 5, width of each register-index field.
REQ-003 Parameter WB_W, default 2, width of the write-back control field.
REQ-004 Parameter M_W, default 3, width of the memory control field.
REQ-005 Parameter ALUOP_W, default 3, width of the ALU-op field; EX field width = ALUOP_W+2.
REQ-006 clkIDEX  in  1  single clock; all state updates on rising edge.
REQ-007 rstIDEX  in  1  reset, asynchronous, active-high.
REQ-008 inValid  in  1  ID stage presents a valid instruction bundle.
REQ-009 inReady  out  1  stage can accept a bundle this cycle; registered.
REQ-010 inWB  in  WB_W; inM  in  M_W  write-back and memory control.
REQ-011 inEX  in  ALUOP_W+2  [0]=RegDst, [ALUOP_W:1]=ALUOp, [ALUOP_W+1]=ALUSrc.
REQ-012 inPC4, inBR1, inBR2, inSE  in  DATA_W each  PC+4, rs data, rt data, sign-extended immediate.
REQ-013 inRt, inRd  in  REG_W each  destination-select candidates.
REQ-014 flush  in  1  kill all held instructions (branch/hazard squash).
REQ-015 outValid  out  1  output bundle valid; outReady  in  1  EX stage accepts.
REQ-016 outWB, outM, outRegDst, outALUOp, outALUSrc  out  decoded control, widths per REQ-010/011.
REQ-017 outPC4, outBR1, outBR2, outSE  out  DATA_W; outRt, outRd  out  REG_W.

Function
REQ-018 Transfer in: inValid && inReady; transfer out: outValid && outReady.
REQ-019 Block SHALL be a two-entry skid register (main + skid) with states EMPTY, ONE, TWO; outputs driven only from main, all registered.
REQ-020 Latency: bundle accepted at edge N SHALL appear on outputs after edge N when main empty or draining that cycle.
REQ-021 EMPTY: in-transfer -> ONE (load main); else stay.
REQ-022 ONE: in-only -> TWO (load skid); out-only -> EMPTY; both -> ONE (main reloaded with input); neither -> stay.
REQ-023 TWO: out-transfer -> ONE (main <= skid); no input accepted; else stay.
REQ-024 inReady SHALL be 1 in EMPTY and ONE, 0 in TWO; outValid SHALL be 1 in ONE and TWO.
REQ-025 Order SHALL be preserved; a bundle SHALL never be dropped or duplicated absent flush.
REQ-026 Output payload SHALL be stable while outValid && !outReady.
REQ-027 flush SHALL take priority over all transfers: next state EMPTY, inputs that cycle discarded, main and skid control fields (WB, M, EX) zeroed.
REQ-028 Data fields need not be cleared on flush; only control fields and valid state matter.
REQ-029 flush while EMPTY SHALL be harmless; flush and outReady same cycle: out-transfer still counts as completed by EX.
REQ-030 Field packing/decoding SHALL be pure bit-select, no arithmetic; widths exact per parameters.

Reset
REQ-031 rstIDEX asserted SHALL immediately force EMPTY, outValid=0, inReady=1, all control and data outputs and skid contents to 0.
REQ-032 Reset mid-operation SHALL discard held bundles; first acceptance allowed on first rising edge after deassertion.

Structure
REQ-033 Field widths' defaults and EX bit positions (RegDst, ALUOp, ALUSrc) SHALL be constants in shared package pipe_pkg; state encoding localparam in module.
REQ-034 One sub-module is natural: id_ex_payload_reg (enable-loaded, clear-on-flush register for one bundle), instantiated twice.

Verification
REQ-035 Reset: assert rstIDEX mid-run with two held -> outValid=0, inReady=1, outWB=0 without clock edge.
REQ-036 Streaming: inValid=1, outReady=1 every cycle, inPC4=4,8,12 -> outPC4=4,8,12 one cycle later each, inReady stays 1.
REQ-037 Backpressure: outReady=0, send inPC4=4,8 -> state TWO, inReady=0, outPC4 holds 4; outReady=1 -> 4 then 8 delivered in order.
REQ-038 Flush: state TWO, flush=1 with inValid=1 -> next cycle outValid=0, outWB=0, outM=0; incoming bundle absent.
REQ-039 Decode: inEX=5'b10111 -> outRegDst=1, outALUOp=3'b011, outALUSrc=1.
REQ-040 Parameter: DATA_W=64, REG_W=6 build -> inSE=64'hFFFF_0000_0000_0001 passes unchanged.
